spart_key_rx: RTL and testbench



---
 rtl/spart_key_rx.sv | 225 ++++++++++++++++++++++
 tb/tb_spart_key_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spart_key_rx.sv
// ============================================================================
// spart_key_rx : 16x-oversampled UART keyboard receiver -> key FIFO -> CPU strobes
// Optional 8E1 framing when SPART_PARITY_EN is defined (default build is 8N1).
// Revision: 1.0
// ============================================================================
`default_nettype none

module spart_key_rx #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  input  logic                          cpu_rdy,
  output logic                          SPART_we,
  output logic [3:0]                    SPART_keys,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int DIV = (CLK_HZ + 8*BAUD) / (16*BAUD);
  localparam int DW  = $clog2(DIV + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SPART_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_q;
  logic            sync1_q, rxd_s_q, rxd_prev_q;
  logic [DW-1:0]   div_q;
  logic [3:0]      tck_q;
  logic [2:0]      bit_cnt_q;
  logic [1:0]      samp_q;
  logic [7:0]      shreg_q;
  logic [7:0]      byte_q;
  logic            byte_valid_q;
  logic            frame_err_q;
`ifdef SPART_PARITY_EN
  logic            par_bad_q;
`endif

  logic            tick_w, fall_w, maj_w;

  assign tick_w = (div_q == DW'(DIV - 1));
  assign fall_w = rxd_prev_q & ~rxd_s_q;
  // samp_q holds the tick-7 and tick-8 samples; the live input is the tick-9 vote
  assign maj_w  = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxd_s_q) | (samp_q[0] & rxd_s_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      rxd_s_q      <= 1'b1;
      rxd_prev_q   <= 1'b1;
    end else begin
      sync1_q      <= rxd;
      rxd_s_q      <= sync1_q;
      rxd_prev_q   <= rxd_s_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      tck_q        <= 4'd0;
      bit_cnt_q    <= 3'd0;
      samp_q       <= 2'b00;
      shreg_q      <= 8'h00;
      byte_q       <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef SPART_PARITY_EN
      par_bad_q    <= 1'b0;
`endif
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      div_q        <= tick_w ? '0 : div_q + DW'(1);
      if (tick_w) begin
        tck_q <= tck_q + 4'd1;
        if (tck_q == 4'd7) samp_q[1] <= rxd_s_q;
        if (tck_q == 4'd8) samp_q[0] <= rxd_s_q;
      end

      case (state_q)
        S_IDLE: begin
          if (fall_w) begin
            state_q <= S_START;
            div_q   <= '0;
            tck_q   <= 4'd0;
          end
        end
        S_START: begin
          if (tick_w && tck_q == 4'd9 && maj_w) begin
            state_q <= S_IDLE;
          end else if (tick_w && tck_q == 4'd15) begin
            state_q   <= S_DATA;
            bit_cnt_q <= 3'd0;
          end
        end
        S_DATA: begin
          if (tick_w && tck_q == 4'd9) shreg_q <= {maj_w, shreg_q[7:1]};
          if (tick_w && tck_q == 4'd15) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef SPART_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end
        end
`ifdef SPART_PARITY_EN
        S_PARITY: begin
          if (tick_w && tck_q == 4'd9) par_bad_q <= (^shreg_q) ^ maj_w;
          if (tick_w && tck_q == 4'd15) state_q <= S_STOP;
        end
`endif
        S_STOP: begin
          if (tick_w && tck_q == 4'd9) begin
            if (maj_w) begin
`ifdef SPART_PARITY_EN
              if (par_bad_q) begin
                frame_err_q <= 1'b1;
              end else begin
                byte_valid_q <= 1'b1;
                byte_q       <= shreg_q;
              end
`else
              byte_valid_q <= 1'b1;
              byte_q       <= shreg_q;
`endif
              state_q <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rxd_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [3:0] key_w;
  always_comb begin
    key_w = 4'h0;
    case (byte_q)
      8'h77, 8'h57: key_w = 4'h1;
      8'h61, 8'h41: key_w = 4'h2;
      8'h73, 8'h53: key_w = 4'h3;
      8'h64, 8'h44: key_w = 4'h4;
      8'h6A, 8'h4A: key_w = 4'h5;
      8'h6B, 8'h4B: key_w = 4'h6;
      8'h20:        key_w = 4'h7;
      8'h0D:        key_w = 4'h8;
      8'h1B:        key_w = 4'hF;
      default:      key_w = 4'h0;
    endcase
  end

  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          we_q, ovr_q;
  logic [3:0]    keys_q;
  logic          push_req_w, full_w, pop_w, push_w;

  assign push_req_w = byte_valid_q & (key_w != 4'h0);
  assign full_w     = (cnt_q == CW'(FIFO_DEPTH));
  // the strobe register doubles as the one-idle-cycle spacer between pops
  assign pop_w      = (cnt_q != '0) & cpu_rdy & ~we_q;
  assign push_w     = push_req_w & (~full_w | pop_w);

  always_ff @(posedge clk) begin
    if (push_w) mem_q[wr_q] <= key_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      we_q   <= 1'b0;
      keys_q <= 4'h0;
      ovr_q  <= 1'b0;
    end else begin
      we_q   <= pop_w;
      keys_q <= pop_w ? mem_q[rd_q] : 4'h0;
      ovr_q  <= push_req_w & full_w & ~pop_w;
      if (push_w) wr_q <= wr_q + AW'(1);
      if (pop_w)  rd_q <= rd_q + AW'(1);
      case ({push_w, pop_w})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign SPART_we   = we_q;
  assign SPART_keys = keys_q;
  assign frame_err  = frame_err_q;
  assign overrun    = ovr_q;
  assign fifo_cnt   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_spart_key_rx.sv
// ============================================================================
// tb_spart_key_rx : directed UART frames with a key-code scoreboard for spart_key_rx
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spart_key_rx;

  localparam int BIT = 217;  // clocks per bit at 25 MHz / 115200
`ifdef SPART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       cpu_rdy = 1'b0;
  logic       SPART_we;
  logic [3:0] SPART_keys;
  logic       frame_err;
  logic       overrun;
  logic [2:0] fifo_cnt;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         we_cnt = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         last_we_cyc = -1;
  int         t0;
  int         f0;
  logic       prev_we = 1'b0;
  logic [3:0] exp_q[$];

  always #20 clk = ~clk;
  always @(posedge clk) cyc++;

  spart_key_rx #(.CLK_HZ(25000000), .BAUD(115200), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .cpu_rdy    (cpu_rdy),
    .SPART_we   (SPART_we),
    .SPART_keys (SPART_keys),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .fifo_cnt   (fifo_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: each strobe pops the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (SPART_we) begin
        we_cnt++;
        last_we_cyc = cyc;
        check("we_gap", {31'd0, prev_we}, 32'd0);
        check("sb_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) check("key", {28'd0, SPART_keys}, {28'd0, exp_q.pop_front()});
      end
      prev_we = SPART_we;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rxd = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit = 1'b1,
                      input logic bad_par = 1'b0, input int rst_bit = -1);
    logic [10:0] fr;
`ifdef SPART_PARITY_EN
    fr = {stop_bit, (^b) ^ bad_par, b, 1'b0};
`else
    fr = {1'b1, stop_bit, b, 1'b0};
`endif
    for (int i = 0; i < NB; i++) begin
      for (int c = 0; c < BIT; c++) begin
        @(negedge clk);
        rxd = fr[i];
        if (i == rst_bit && c == BIT/2) rst = 1'b1;
        if (i == rst_bit && c == BIT/2 + 5) begin
          check("rst_we",   {31'd0, SPART_we},   32'd0);
          check("rst_keys", {28'd0, SPART_keys}, 32'd0);
          check("rst_ferr", {31'd0, frame_err},  32'd0);
          check("rst_ovr",  {31'd0, overrun},    32'd0);
          check("rst_cnt",  {29'd0, fifo_cnt},   32'd0);
        end
        if (i == rst_bit && c == BIT/2 + 10) rst = 1'b0;
      end
    end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check("init_we",   {31'd0, SPART_we},   32'd0);
    check("init_keys", {28'd0, SPART_keys}, 32'd0);
    check("init_ferr", {31'd0, frame_err},  32'd0);
    check("init_ovr",  {31'd0, overrun},    32'd0);
    check("init_cnt",  {29'd0, fifo_cnt},   32'd0);
    rst = 1'b0;
    idle(50);

    // single 'w' with latency window around the stop bit
    cpu_rdy = 1'b1;
    t0 = cyc;
    exp_q.push_back(4'h1);
    send(8'h77);
    idle(3*BIT);
    check("w_count", we_cnt, 1);
    check("w_lat_lo", {31'd0, last_we_cyc >= t0 + (NB-1)*BIT}, 32'd1);
    check("w_lat_hi", {31'd0, last_we_cyc <= t0 + NB*BIT + 3}, 32'd1);
    check("w_cnt0", {29'd0, fifo_cnt}, 32'd0);

    // 'A', 'x', ESC back-to-back; 'x' silently dropped
    exp_q.push_back(4'h2);
    exp_q.push_back(4'hF);
    send(8'h41);
    send(8'h78);
    send(8'h1B);
    idle(3*BIT);
    check("b2b_count", we_cnt, 3);
    check("b2b_ferr", ferr_cnt, 0);
    check("b2b_sb_empty", exp_q.size(), 0);

    // fill FIFO while CPU stalled; fifth key overruns
    cpu_rdy = 1'b0;
    exp_q.push_back(4'h1);
    exp_q.push_back(4'h2);
    exp_q.push_back(4'h3);
    exp_q.push_back(4'h4);
    send(8'h77);
    send(8'h61);
    send(8'h73);
    send(8'h64);
    send(8'h6A);
    idle(2*BIT);
    check("full_cnt", {29'd0, fifo_cnt}, 32'd4);
    check("full_ovr", ovr_cnt, 1);
    check("full_nowe", we_cnt, 3);
    cpu_rdy = 1'b1;
    idle(50);
    check("drain_count", we_cnt, 7);
    check("drain_sb_empty", exp_q.size(), 0);
    check("drain_cnt0", {29'd0, fifo_cnt}, 32'd0);

    // short low glitch on idle line
    repeat (3) begin
      @(negedge clk);
      rxd = 1'b0;
    end
    idle(3*BIT);
    check("glitch_we", we_cnt, 7);
    check("glitch_ferr", ferr_cnt, 0);

    // bad stop bit followed by a held break
    send(8'h77, 1'b0);
    repeat (2*BIT) begin
      @(negedge clk);
      rxd = 1'b0;
    end
    idle(BIT);
    check("stop_ferr", ferr_cnt, 1);
    check("stop_nowe", we_cnt, 7);
    exp_q.push_back(4'h3);
    send(8'h73);
    idle(3*BIT);
    check("after_break_we", we_cnt, 8);
    check("after_break_sb", exp_q.size(), 0);

    // reset mid-frame clears the queued key and the partial frame
    cpu_rdy = 1'b0;
    send(8'h6A);
    idle(2*BIT);
    check("pre_rst_cnt", {29'd0, fifo_cnt}, 32'd1);
    send(8'h64, 1'b1, 1'b0, 5);
    idle(12*BIT);
    check("post_rst_cnt", {29'd0, fifo_cnt}, 32'd0);
    cpu_rdy = 1'b1;
    idle(BIT);
    check("post_rst_nowe", we_cnt, 8);
    exp_q.push_back(4'h6);
    send(8'h6B);
    idle(3*BIT);
    check("k_we", we_cnt, 9);
    check("k_sb_empty", exp_q.size(), 0);

`ifdef SPART_PARITY_EN
    f0 = ferr_cnt;
    send(8'h77, 1'b1, 1'b1);
    idle(3*BIT);
    check("par_bad_ferr", ferr_cnt, f0 + 1);
    check("par_bad_nowe", we_cnt, 9);
    exp_q.push_back(4'h1);
    send(8'h77);
    idle(3*BIT);
    check("par_ok_we", we_cnt, 10);
    check("par_ok_ferr", ferr_cnt, f0 + 1);
`endif

    check("final_sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
